// File: rtl/pwm_decoder_if.sv
// Signal bundle between a PWM source (master) and the pwm_decoder (slave).
interface pwm_decoder_if #(
    parameter int DW = 4,
    parameter int PW = 8
);
    logic          pwm_in;
    logic [DW-1:0] duty_cycle;
    logic [PW-1:0] period;
    logic          valid;
    logic          stuck;

    modport master (output pwm_in, input duty_cycle, period, valid, stuck);
    modport slave  (input pwm_in, output duty_cycle, period, valid, stuck);
endinterface

// File: rtl/pwm_decoder.sv
// Recovers duty cycle and period of an asynchronous PWM input, flagging an input
// that stops toggling. The interface instance must use the same DW/PW as this module.
module pwm_decoder #(
    parameter int DW      = 4,
    parameter int PW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    pwm_decoder_if.slave bus
);
    localparam logic [PW-1:0] CNT_MAX      = {PW{1'b1}};
    localparam logic [DW-1:0] DUTY_MAX     = {DW{1'b1}};
    localparam logic [PW-1:0] TIMEOUT_LAST = PW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, MEASURE, STUCK_LO, STUCK_HI} state_t;

    state_t        state;
    state_t        state_next;
    logic          s1;
    logic          s2;
    logic          s2_d;
    logic          rise;
    logic          timeout_hit;
    logic [PW-1:0] per_cnt;
    logic [PW-1:0] hi_cnt;
    logic [DW-1:0] duty_sat;
    logic [DW-1:0] duty_reg;
    logic [PW-1:0] period_reg;
    logic          valid_reg;
    logic          stuck_reg;
    logic          cnt_load;
    logic          per_inc;
    logic          hi_inc;
    logic          publish;
    logic          enter_stuck;
    logic          leave_stuck;

    assign rise        = s2 & ~s2_d;
    assign timeout_hit = (per_cnt == TIMEOUT_LAST);

    // Compare in a width that holds both operands so any DW/PW combination works.
    assign duty_sat = ({{DW{1'b0}}, hi_cnt} > {{PW{1'b0}}, DUTY_MAX}) ? DUTY_MAX
                                                                        : DW'(hi_cnt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, MEASURE: begin
                if (rise) begin
                    state_next = MEASURE;
                end else if (timeout_hit) begin
                    state_next = s2 ? STUCK_HI : STUCK_LO;
                end
            end
            STUCK_LO, STUCK_HI: begin
                if (rise) begin
                    state_next = MEASURE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A rise always beats the timeout; stuck states freeze the counters.
    always_comb begin
        cnt_load    = rise;
        per_inc     = 1'b0;
        hi_inc      = 1'b0;
        publish     = 1'b0;
        enter_stuck = 1'b0;
        leave_stuck = 1'b0;
        case (state)
            IDLE: begin
                per_inc     = !rise && !timeout_hit;
                enter_stuck = !rise && timeout_hit;
            end
            MEASURE: begin
                publish     = rise;
                per_inc     = !rise && !timeout_hit;
                hi_inc      = !rise && !timeout_hit && s2;
                enter_stuck = !rise && timeout_hit;
            end
            STUCK_LO, STUCK_HI: begin
                leave_stuck = rise;
            end
            default: begin
                cnt_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s2_d       <= 1'b0;
            per_cnt    <= '0;
            hi_cnt     <= '0;
            duty_reg   <= '0;
            period_reg <= '0;
            valid_reg  <= 1'b0;
            stuck_reg  <= 1'b0;
        end else begin
            s1        <= bus.pwm_in;
            s2        <= s1;
            s2_d      <= s2;
            valid_reg <= publish | enter_stuck;

            if (cnt_load) begin
                per_cnt <= PW'(1);
                hi_cnt  <= PW'(1);
            end else begin
                if (per_inc && per_cnt != CNT_MAX) begin
                    per_cnt <= per_cnt + PW'(1);
                end
                if (hi_inc && hi_cnt != CNT_MAX) begin
                    hi_cnt <= hi_cnt + PW'(1);
                end
            end

            if (publish) begin
                period_reg <= per_cnt;
                duty_reg   <= duty_sat;
            end else if (enter_stuck) begin
                period_reg <= '0;
                duty_reg   <= s2 ? DUTY_MAX : '0;
                stuck_reg  <= 1'b1;
            end else if (leave_stuck) begin
                stuck_reg  <= 1'b0;
            end
        end
    end

    assign bus.duty_cycle = duty_reg;
    assign bus.period     = period_reg;
    assign bus.valid      = valid_reg;
    assign bus.stuck      = stuck_reg;
endmodule

// File: tb/tb_pwm_decoder.sv
// Directed and randomized check of pwm_decoder against a cycle-level reference model.
module tb_pwm_decoder;
    localparam int DW       = 4;
    localparam int PW       = 8;
    localparam int TIMEOUT  = 64;
    localparam int DUTY_MAX = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    // Reference model: delay line for the synchronizer plus period bookkeeping.
    bit m_h0, m_h1, m_h2;
    int m_mode;
    int m_count;
    int m_highs;
    int exp_duty, exp_period, exp_valid, exp_stuck;

    int valid_seen;
    int last_duty;
    int last_period;

    pwm_decoder_if #(.DW(DW), .PW(PW)) bus ();

    pwm_decoder #(.DW(DW), .PW(PW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, observed, expected);
        end
    endtask

    task automatic modelEdge(input logic level, input logic rst_level);
        bit rise;
        if (!rst_level) begin
            m_h0 = 0; m_h1 = 0; m_h2 = 0;
            m_mode = 0; m_count = 0; m_highs = 0;
            exp_duty = 0; exp_period = 0; exp_valid = 0; exp_stuck = 0;
        end else begin
            rise = m_h1 && !m_h2;
            exp_valid = 0;
            if (rise) begin
                if (m_mode == 1) begin
                    exp_valid  = 1;
                    exp_period = m_count;
                    exp_duty   = (m_highs > DUTY_MAX) ? DUTY_MAX : m_highs;
                end
                exp_stuck = 0;
                m_mode = 1; m_count = 1; m_highs = 1;
            end else if (m_mode != 2 && m_count == TIMEOUT - 1) begin
                exp_valid  = 1;
                exp_stuck  = 1;
                exp_period = 0;
                exp_duty   = m_h1 ? DUTY_MAX : 0;
                m_mode = 2;
            end else if (m_mode != 2) begin
                m_count++;
                if (m_mode == 1 && m_h1) m_highs++;
            end
            m_h2 = m_h1; m_h1 = m_h0; m_h0 = level;
        end
    endtask

    task automatic applyStimulus(input logic level, input logic rst_level);
        @(negedge clk);
        bus.pwm_in = level;
        rst_n      = rst_level;
        @(posedge clk);
        modelEdge(level, rst_level);
        #1;
        checkOutput("valid",  bus.valid,      exp_valid);
        checkOutput("stuck",  bus.stuck,      exp_stuck);
        checkOutput("duty",   bus.duty_cycle, exp_duty);
        checkOutput("period", bus.period,     exp_period);
        if (bus.valid === 1'b1) begin
            valid_seen++;
            last_duty   = int'(bus.duty_cycle);
            last_period = int'(bus.period);
        end
    endtask

    task automatic sendPeriods(input int per, input int high, input int n);
        for (int p = 0; p < n; p++)
            for (int i = 0; i < per; i++)
                applyStimulus(i < high, 1'b1);
    endtask

    task automatic holdLevel(input logic level, input int n);
        for (int i = 0; i < n; i++) applyStimulus(level, 1'b1);
    endtask

    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
    endtask

    initial begin
        int per, high;
        bus.pwm_in = 1'b0;

        doReset(3);
        checkOutput("rst_duty",   bus.duty_cycle, 0);
        checkOutput("rst_period", bus.period,     0);
        checkOutput("rst_valid",  bus.valid,      0);
        checkOutput("rst_stuck",  bus.stuck,      0);

        // Steady 16/4: the first rise only opens a period.
        valid_seen = 0;
        sendPeriods(16, 4, 6);
        checkOutput("steady_count",  valid_seen,  5);
        checkOutput("steady_duty",   last_duty,   4);
        checkOutput("steady_period", last_period, 16);

        valid_seen = 0;
        sendPeriods(16, 3, 4);
        sendPeriods(16, 7, 4);
        checkOutput("switch_count", valid_seen, 8);
        checkOutput("switch_duty",  last_duty,  7);

        valid_seen = 0;
        holdLevel(1'b0, 70);
        checkOutput("lo_count",  valid_seen,  1);
        checkOutput("lo_stuck",  bus.stuck,   1);
        checkOutput("lo_duty",   last_duty,   0);
        checkOutput("lo_period", last_period, 0);
        valid_seen = 0;
        sendPeriods(16, 4, 3);
        checkOutput("recover_count",  valid_seen,  2);
        checkOutput("recover_stuck",  bus.stuck,   0);
        checkOutput("recover_period", last_period, 16);

        sendPeriods(20, 18, 4);
        checkOutput("sat_duty",   last_duty,   DUTY_MAX);
        checkOutput("sat_period", last_period, 20);

        // Reset in the middle of a period discards it.
        sendPeriods(16, 4, 2);
        for (int i = 0; i < 8; i++) applyStimulus(i < 4, 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("midrst_duty",   bus.duty_cycle, 0);
        checkOutput("midrst_period", bus.period,     0);
        valid_seen = 0;
        sendPeriods(16, 4, 3);
        checkOutput("midrst_count",  valid_seen,  2);
        checkOutput("midrst_result", last_duty,   4);

        doReset(2);
        valid_seen = 0;
        holdLevel(1'b1, 80);
        checkOutput("hi_count",  valid_seen,  1);
        checkOutput("hi_stuck",  bus.stuck,   1);
        checkOutput("hi_duty",   last_duty,   DUTY_MAX);
        checkOutput("hi_period", last_period, 0);

        for (int k = 0; k < 250; k++) begin
            case ($urandom_range(19))
                0, 1:    holdLevel(1'($urandom_range(1)), $urandom_range(90, 40));
                2:       doReset($urandom_range(2, 1));
                3:       for (int i = 0; i < 8; i++) applyStimulus(1'($urandom_range(1)), 1'b1);
                default: begin
                    per  = $urandom_range(40, 2);
                    high = $urandom_range(per - 1, 1);
                    sendPeriods(per, high, $urandom_range(3, 1));
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
